mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single 12-bit address / 8-bit data memory port between the cpu core and a secondary DMA/debug requester.
- Each requester issues single-byte read or write transactions through a req/gnt/done handshake.
- The arbiter sequences one transaction at a time against a fixed-latency memory.
- Ties are resolved round-robin, and a lock input lets the cpu hold the bus across a multi-byte instruction.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : mem_arbiter_if
// Brief  : Requester, memory and status signals of the two-port memory arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpuReq;
    logic              cpuLock;
    logic [ADDR_W-1:0] cpuAddr;
    logic              cpuWrite;
    logic [DATA_W-1:0] cpuWdata;
    logic              cpuGnt;
    logic              cpuDone;
    logic [DATA_W-1:0] cpuRdata;

    logic              dmaReq;
    logic [ADDR_W-1:0] dmaAddr;
    logic              dmaWrite;
    logic [DATA_W-1:0] dmaWdata;
    logic              dmaGnt;
    logic              dmaDone;
    logic [DATA_W-1:0] dmaRdata;

    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memWrite;
    logic              memEnable;
    logic [DATA_W-1:0] memRdata;

    logic              busOwner;
    logic              busy;

    modport slave (
        input  cpuReq, cpuLock, cpuAddr, cpuWrite, cpuWdata,
        input  dmaReq, dmaAddr, dmaWrite, dmaWdata, memRdata,
        output cpuGnt, cpuDone, cpuRdata, dmaGnt, dmaDone, dmaRdata,
        output memAddr, memWdata, memWrite, memEnable, busOwner, busy
    );

    modport master (
        output cpuReq, cpuLock, cpuAddr, cpuWrite, cpuWdata,
        output dmaReq, dmaAddr, dmaWrite, dmaWdata, memRdata,
        input  cpuGnt, cpuDone, cpuRdata, dmaGnt, dmaDone, dmaRdata,
        input  memAddr, memWdata, memWrite, memEnable, busOwner, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Round-robin cpu/DMA arbiter for one fixed-latency memory port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic    clock,
    input  wire logic    resetN,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam logic [3:0] C_LATENCY = 4'(MEM_LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              memWrite_q, memWrite_d;
    logic              memEnable_q, memEnable_d;
    logic              isWrite_q, isWrite_d;
    logic              cpuGnt_q, cpuGnt_d;
    logic              dmaGnt_q, dmaGnt_d;
    logic              cpuDone_q, cpuDone_d;
    logic              dmaDone_q, dmaDone_d;
    logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
    logic [DATA_W-1:0] dmaRdata_q, dmaRdata_d;
    logic              busOwner_q, busOwner_d;
    logic              lastOwner_q, lastOwner_d;
    logic              busy_q, busy_d;

    logic              w_cpuElig;
    logic              w_dmaElig;
    logic              w_winner;

    // lastOwner resets to DMA so that the cpu wins the first tie.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memWrite_q  <= 1'b0;
            memEnable_q <= 1'b0;
            isWrite_q   <= 1'b0;
            cpuGnt_q    <= 1'b0;
            dmaGnt_q    <= 1'b0;
            cpuDone_q   <= 1'b0;
            dmaDone_q   <= 1'b0;
            cpuRdata_q  <= '0;
            dmaRdata_q  <= '0;
            busOwner_q  <= 1'b0;
            lastOwner_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            memWrite_q  <= memWrite_d;
            memEnable_q <= memEnable_d;
            isWrite_q   <= isWrite_d;
            cpuGnt_q    <= cpuGnt_d;
            dmaGnt_q    <= dmaGnt_d;
            cpuDone_q   <= cpuDone_d;
            dmaDone_q   <= dmaDone_d;
            cpuRdata_q  <= cpuRdata_d;
            dmaRdata_q  <= dmaRdata_d;
            busOwner_q  <= busOwner_d;
            lastOwner_q <= lastOwner_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        memWrite_d  = 1'b0;
        memEnable_d = 1'b0;
        isWrite_d   = isWrite_q;
        cpuGnt_d    = 1'b0;
        dmaGnt_d    = 1'b0;
        cpuDone_d   = 1'b0;
        dmaDone_d   = 1'b0;
        cpuRdata_d  = cpuRdata_q;
        dmaRdata_d  = dmaRdata_q;
        busOwner_d  = busOwner_q;
        lastOwner_d = lastOwner_q;
        busy_d      = busy_q;

        w_cpuElig   = bus.cpuReq;
        w_dmaElig   = bus.dmaReq & ~bus.cpuLock;
        w_winner    = (w_cpuElig & w_dmaElig) ? ~lastOwner_q : w_dmaElig;

        case (state_q)
            S_IDLE: begin
                if (w_cpuElig | w_dmaElig) begin
                    state_d     = S_ACCESS;
                    cnt_d       = C_LATENCY;
                    memEnable_d = 1'b1;
                    busy_d      = 1'b1;
                    busOwner_d  = w_winner;
                    lastOwner_d = w_winner;
                    if (w_winner) begin
                        memAddr_d  = bus.dmaAddr;
                        memWdata_d = bus.dmaWdata;
                        memWrite_d = bus.dmaWrite;
                        isWrite_d  = bus.dmaWrite;
                        dmaGnt_d   = 1'b1;
                    end else begin
                        memAddr_d  = bus.cpuAddr;
                        memWdata_d = bus.cpuWdata;
                        memWrite_d = bus.cpuWrite;
                        isWrite_d  = bus.cpuWrite;
                        cpuGnt_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Count 1 marks the edge on which memRdata is valid.
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (busOwner_q) begin
                        dmaDone_d = 1'b1;
                        if (!isWrite_q) dmaRdata_d = bus.memRdata;
                    end else begin
                        cpuDone_d = 1'b1;
                        if (!isWrite_q) cpuRdata_d = bus.memRdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cpuGnt    = cpuGnt_q;
    assign bus.cpuDone   = cpuDone_q;
    assign bus.cpuRdata  = cpuRdata_q;
    assign bus.dmaGnt    = dmaGnt_q;
    assign bus.dmaDone   = dmaDone_q;
    assign bus.dmaRdata  = dmaRdata_q;
    assign bus.memAddr   = memAddr_q;
    assign bus.memWdata  = memWdata_q;
    assign bus.memWrite  = memWrite_q;
    assign bus.memEnable = memEnable_q;
    assign bus.busOwner  = busOwner_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter at MEM_LATENCY 1 and 3.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    logic        cpuReq, cpuLock, cpuWrite, dmaReq, dmaWrite;
    logic [11:0] cpuAddr, dmaAddr;
    logic [7:0]  cpuWdata, dmaWdata;
    logic        sel = 1'b0;
    int          checks = 0;
    int          failures = 0;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) if0 ();
    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) if1 ();

    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MEM_LATENCY(1)) dut0 (
        .clock(clock), .resetN(resetN), .bus(if0.slave));
    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MEM_LATENCY(3)) dut1 (
        .clock(clock), .resetN(resetN), .bus(if1.slave));

    // Only the selected instance sees requests; the other stays idle.
    assign if0.cpuReq = cpuReq & ~sel;   assign if1.cpuReq = cpuReq & sel;
    assign if0.dmaReq = dmaReq & ~sel;   assign if1.dmaReq = dmaReq & sel;
    assign if0.cpuLock  = cpuLock;  assign if1.cpuLock  = cpuLock;
    assign if0.cpuAddr  = cpuAddr;  assign if1.cpuAddr  = cpuAddr;
    assign if0.cpuWrite = cpuWrite; assign if1.cpuWrite = cpuWrite;
    assign if0.cpuWdata = cpuWdata; assign if1.cpuWdata = cpuWdata;
    assign if0.dmaAddr  = dmaAddr;  assign if1.dmaAddr  = dmaAddr;
    assign if0.dmaWrite = dmaWrite; assign if1.dmaWrite = dmaWrite;
    assign if0.dmaWdata = dmaWdata; assign if1.dmaWdata = dmaWdata;

    logic        oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy, oOwner;
    logic [7:0]  oCpuRd, oDmaRd, oMemWd;
    logic [11:0] oMemA;
    assign oCpuGnt  = sel ? if1.cpuGnt    : if0.cpuGnt;
    assign oDmaGnt  = sel ? if1.dmaGnt    : if0.dmaGnt;
    assign oCpuDone = sel ? if1.cpuDone   : if0.cpuDone;
    assign oDmaDone = sel ? if1.dmaDone   : if0.dmaDone;
    assign oMemEn   = sel ? if1.memEnable : if0.memEnable;
    assign oMemWr   = sel ? if1.memWrite  : if0.memWrite;
    assign oBusy    = sel ? if1.busy      : if0.busy;
    assign oOwner   = sel ? if1.busOwner  : if0.busOwner;
    assign oCpuRd   = sel ? if1.cpuRdata  : if0.cpuRdata;
    assign oDmaRd   = sel ? if1.dmaRdata  : if0.dmaRdata;
    assign oMemWd   = sel ? if1.memWdata  : if0.memWdata;
    assign oMemA    = sel ? if1.memAddr   : if0.memAddr;

    // Unwritten locations read back a fixed address-derived pattern (0x0A5 -> 0x3C).
    function automatic logic [7:0] seed_val(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h99;
    endfunction

    // Memory model: data is driven only in cycle MEM_LATENCY after the access cycle.
    logic        memEn [2];
    logic        memWr [2];
    logic [11:0] memA  [2];
    logic [7:0]  memWd [2];
    logic [7:0]  memRd [2];
    logic [7:0]  mem   [2][4096];
    bit          vld   [2][4096];
    int          age   [2] = '{100, 100};
    assign memEn[0] = if0.memEnable; assign memEn[1] = if1.memEnable;
    assign memWr[0] = if0.memWrite;  assign memWr[1] = if1.memWrite;
    assign memA[0]  = if0.memAddr;   assign memA[1]  = if1.memAddr;
    assign memWd[0] = if0.memWdata;  assign memWd[1] = if1.memWdata;
    assign if0.memRdata = memRd[0];  assign if1.memRdata = memRd[1];

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (memEn[i]) begin
                age[i] = 0;
                if (memWr[i]) begin
                    mem[i][memA[i]] = memWd[i];
                    vld[i][memA[i]] = 1'b1;
                end
            end else if (age[i] < 100) begin
                age[i] = age[i] + 1;
            end
            if (age[i] == ((i == 0) ? 1 : 3))
                memRd[i] = vld[i][memA[i]] ? mem[i][memA[i]] : seed_val(memA[i]);
            else
                memRd[i] = 8'($urandom);
        end
    end

    logic [7:0] refMem [int];

    function automatic logic [7:0] ref_rd(input logic s, input logic [11:0] a);
        int key;
        key = (s ? 4096 : 0) + int'(a);
        return refMem.exists(key) ? refMem[key] : seed_val(a);
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        cpuReq = 1'b0; cpuLock = 1'b0; cpuWrite = 1'b0; cpuAddr = '0; cpuWdata = '0;
        dmaReq = 1'b0; dmaWrite = 1'b0; dmaAddr = '0; dmaWdata = '0;
        tick(); tick();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            resetN = 1'b0;
            tick();
            checks++;
            if ({oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy, oOwner} !== 8'h00) begin
                failures++;
                $display("FAIL reset_strobes inst%0d: got %b expected 00000000", s,
                         {oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy, oOwner});
            end
            checks++;
            if ({oCpuRd, oDmaRd} !== 16'h0) begin
                failures++;
                $display("FAIL reset_rdata inst%0d: got %h expected 0000", s, {oCpuRd, oDmaRd});
            end
            checks++;
            if ({oMemA, oMemWd} !== 20'h0) begin
                failures++;
                $display("FAIL reset_membus inst%0d: got %h expected 00000", s, {oMemA, oMemWd});
            end
        end
    endtask

    task automatic test_cpu_read();
        sel = 1'b0;
        do_reset();
        cpuReq = 1'b1; cpuAddr = 12'h0A5; cpuWrite = 1'b0; cpuWdata = 8'hEE;
        tick();
        checks++;
        if ({oCpuGnt, oMemEn, oMemWr, oBusy, oOwner, oDmaGnt, oMemA} !== {6'b110100, 12'h0A5}) begin
            failures++;
            $display("FAIL cpu_read_grant: got %b/%h expected 110100/0a5",
                     {oCpuGnt, oMemEn, oMemWr, oBusy, oOwner, oDmaGnt}, oMemA);
        end
        cpuReq = 1'b0;
        tick();
        checks++;
        if ({oCpuGnt, oMemEn, oCpuDone, oBusy, oDmaGnt} !== 5'b00010) begin
            failures++;
            $display("FAIL cpu_read_wait: got %b expected 00010", {oCpuGnt, oMemEn, oCpuDone, oBusy, oDmaGnt});
        end
        tick();
        checks++;
        if ({oCpuDone, oBusy, oDmaGnt, oDmaDone, oCpuRd} !== {4'b1000, 8'h3C}) begin
            failures++;
            $display("FAIL cpu_read_done: got %b/%h expected 1000/3c", {oCpuDone, oBusy, oDmaGnt, oDmaDone}, oCpuRd);
        end
        tick();
        checks++;
        if ({oCpuDone, oCpuGnt, oCpuRd, oMemA} !== {2'b00, 8'h3C, 12'h0A5}) begin
            failures++;
            $display("FAIL cpu_read_hold: got %b/%h/%h expected 00/3c/0a5", {oCpuDone, oCpuGnt}, oCpuRd, oMemA);
        end
    endtask

    task automatic test_dma_write();
        logic [4:0] expv;
        sel = 1'b1;
        do_reset();
        dmaReq = 1'b1; dmaAddr = 12'hFFF; dmaWdata = 8'h81; dmaWrite = 1'b1;
        tick();
        checks++;
        if ({oDmaGnt, oMemEn, oMemWr, oBusy, oOwner, oCpuGnt, oMemA, oMemWd} !== {6'b111110, 12'hFFF, 8'h81}) begin
            failures++;
            $display("FAIL dma_write_grant: got %b/%h/%h expected 111110/fff/81",
                     {oDmaGnt, oMemEn, oMemWr, oBusy, oOwner, oCpuGnt}, oMemA, oMemWd);
        end
        dmaReq = 1'b0; dmaWrite = 1'b0;
        refMem[4096 + 4095] = 8'h81;
        for (int c = 1; c <= 5; c++) begin
            tick();
            expv = {1'b0, 1'b0, (c == 4), (c < 4), 1'b0};
            checks++;
            if ({oMemEn, oMemWr, oDmaDone, oBusy, oCpuDone} !== expv) begin
                failures++;
                $display("FAIL dma_write_cycle%0d: got %b expected %b", c, {oMemEn, oMemWr, oDmaDone, oBusy, oCpuDone}, expv);
            end
        end
        checks++;
        if ({oDmaRd, oOwner, oMemA, oMemWd} !== {8'h00, 1'b1, 12'hFFF, 8'h81}) begin
            failures++;
            $display("FAIL dma_write_after: got %h/%b/%h/%h expected 00/1/fff/81", oDmaRd, oOwner, oMemA, oMemWd);
        end
    endtask

    task automatic test_alternate();
        logic [5:0] expv;
        int k, ph;
        sel = 1'b0;
        do_reset();
        cpuReq = 1'b1; cpuAddr = 12'h100; dmaReq = 1'b1; dmaAddr = 12'h200;
        for (int t = 0; t < 12; t++) begin
            tick();
            k = t / 3; ph = t % 3;
            expv = {(ph == 0) && (k % 2 == 0), (ph == 0) && (k % 2 == 1),
                    (ph == 2) && (k % 2 == 0), (ph == 2) && (k % 2 == 1), (ph != 2), (k % 2 == 1)};
            checks++;
            if ({oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oBusy, oOwner} !== expv) begin
                failures++;
                $display("FAIL alternate_t%0d: got %b expected %b", t, {oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oBusy, oOwner}, expv);
            end
        end
        cpuReq = 1'b0; dmaReq = 1'b0;
    endtask

    task automatic test_lock();
        int nC, nD;
        sel = 1'b1;
        do_reset();
        nC = 0; nD = 0;
        cpuLock = 1'b1; cpuReq = 1'b1; dmaReq = 1'b1; cpuAddr = 12'h300; dmaAddr = 12'h400;
        for (int t = 0; t < 15; t++) begin
            tick();
            nC += int'(oCpuGnt);
            nD += int'(oDmaGnt);
        end
        checks++;
        if (nC != 3 || nD != 0) begin
            failures++;
            $display("FAIL lock_grants: got cpu=%0d dma=%0d expected cpu=3 dma=0", nC, nD);
        end
        cpuLock = 1'b0;
        tick();
        checks++;
        if ({oCpuGnt, oDmaGnt} !== 2'b01) begin
            failures++;
            $display("FAIL lock_release: got %b expected 01", {oCpuGnt, oDmaGnt});
        end
        cpuReq = 1'b0; dmaReq = 1'b0;
    endtask

    task automatic test_reset_abort();
        sel = 1'b1;
        do_reset();
        cpuReq = 1'b1; cpuAddr = 12'h011;
        tick();
        cpuReq = 1'b0;
        repeat (4) tick();
        checks++;
        if ({oCpuDone, oCpuRd} !== {1'b1, seed_val(12'h011)}) begin
            failures++;
            $display("FAIL abort_preread: got %b/%h expected 1/%h", oCpuDone, oCpuRd, seed_val(12'h011));
        end
        cpuReq = 1'b1; cpuAddr = 12'h022;
        tick();
        cpuReq = 1'b0;
        tick(); tick();
        checks++;
        if (oBusy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got %b expected 1", oBusy);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if ({oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy, oCpuRd, oDmaRd} !== 23'h0) begin
            failures++;
            $display("FAIL abort_immediate: got %b/%h/%h expected 0000000/00/00",
                     {oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy}, oCpuRd, oDmaRd);
        end
        tick();
        resetN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({oCpuDone, oBusy} !== 2'b00) begin
                failures++;
                $display("FAIL abort_no_done_c%0d: got %b expected 00", c, {oCpuDone, oBusy});
            end
        end
        cpuReq = 1'b1; dmaReq = 1'b1;
        tick();
        checks++;
        if ({oCpuGnt, oDmaGnt} !== 2'b10) begin
            failures++;
            $display("FAIL abort_first_tie: got %b expected 10", {oCpuGnt, oDmaGnt});
        end
        cpuReq = 1'b0; dmaReq = 1'b0;
    endtask

    task automatic test_dma_pulse();
        sel = 1'b1;
        do_reset();
        cpuReq = 1'b1; cpuAddr = 12'h033;
        tick();
        cpuReq = 1'b0;
        tick();
        dmaReq = 1'b1; dmaAddr = 12'h044;
        tick();
        dmaReq = 1'b0;
        checks++;
        if (oDmaGnt !== 1'b0) begin
            failures++;
            $display("FAIL pulse_c2: got dmaGnt=%b expected 0", oDmaGnt);
        end
        for (int c = 3; c < 10; c++) begin
            tick();
            checks++;
            if ({oDmaGnt, oDmaDone, oCpuDone} !== {2'b00, (c == 4)}) begin
                failures++;
                $display("FAIL pulse_c%0d: got %b expected %b", c, {oDmaGnt, oDmaDone, oCpuDone}, {2'b00, (c == 4)});
            end
        end
    endtask

    // Transaction-level model: grant at edge k completes at k+L+1, bus free again at k+L+2.
    task automatic test_random(input logic s, input int n);
        int          lat, doneEdge, grantEdge, nextFree;
        logic        lastOwn, owner, txWrite, gC, gD, dC, dD, eBusy;
        logic [11:0] expA;
        logic [7:0]  expWd, expRd, expCpuRd, expDmaRd, expv;
        sel = s;
        lat = s ? 3 : 1;
        do_reset();
        doneEdge = -1; grantEdge = -1; nextFree = 0;
        lastOwn = 1'b1; owner = 1'b0; txWrite = 1'b0;
        expA = '0; expWd = '0; expRd = '0; expCpuRd = '0; expDmaRd = '0;
        for (int k = 0; k < n; k++) begin
            cpuReq   = ($urandom_range(0, 9) < 6);
            dmaReq   = ($urandom_range(0, 9) < 6);
            cpuLock  = ($urandom_range(0, 3) == 0);
            cpuWrite = 1'($urandom_range(0, 1));
            dmaWrite = 1'($urandom_range(0, 1));
            cpuAddr  = 12'($urandom_range(0, 63));
            dmaAddr  = 12'($urandom_range(0, 63));
            cpuWdata = 8'($urandom);
            dmaWdata = 8'($urandom);
            gC = 1'b0; gD = 1'b0; dC = 1'b0; dD = 1'b0;
            if (k == doneEdge) begin
                if (owner) dD = 1'b1; else dC = 1'b1;
                if (!txWrite) begin
                    if (owner) expDmaRd = expRd; else expCpuRd = expRd;
                end
            end
            if (k >= nextFree && (cpuReq || (dmaReq && !cpuLock))) begin
                owner   = (cpuReq && dmaReq && !cpuLock) ? ~lastOwn : !cpuReq;
                lastOwn = owner;
                expA    = owner ? dmaAddr  : cpuAddr;
                expWd   = owner ? dmaWdata : cpuWdata;
                txWrite = owner ? dmaWrite : cpuWrite;
                if (txWrite) refMem[(s ? 4096 : 0) + int'(expA)] = expWd;
                else         expRd = ref_rd(s, expA);
                gC = !owner; gD = owner;
                grantEdge = k; doneEdge = k + lat + 1; nextFree = k + lat + 2;
            end
            eBusy = (grantEdge <= k) && (k < doneEdge);
            expv  = {gC, gD, dC, dD, gC | gD, (gC | gD) & txWrite, eBusy, owner};
            tick();
            checks++;
            if ({oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy, oOwner} !== expv) begin
                failures++;
                $display("FAIL rand%0d_strobes k=%0d: got %b expected %b", s, k,
                         {oCpuGnt, oDmaGnt, oCpuDone, oDmaDone, oMemEn, oMemWr, oBusy, oOwner}, expv);
            end
            checks++;
            if ({oMemA, oMemWd} !== {expA, expWd}) begin
                failures++;
                $display("FAIL rand%0d_membus k=%0d: got %h/%h expected %h/%h", s, k, oMemA, oMemWd, expA, expWd);
            end
            checks++;
            if ({oCpuRd, oDmaRd} !== {expCpuRd, expDmaRd}) begin
                failures++;
                $display("FAIL rand%0d_rdata k=%0d: got %h/%h expected %h/%h", s, k, oCpuRd, oDmaRd, expCpuRd, expDmaRd);
            end
        end
        cpuReq = 1'b0; dmaReq = 1'b0; cpuLock = 1'b0;
    endtask

    initial begin
        cpuReq = 1'b0; cpuLock = 1'b0; cpuWrite = 1'b0; cpuAddr = '0; cpuWdata = '0;
        dmaReq = 1'b0; dmaWrite = 1'b0; dmaAddr = '0; dmaWdata = '0;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_alternate();
        test_lock();
        test_reset_abort();
        test_dma_pulse();
        test_random(1'b0, 300);
        test_random(1'b1, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
